// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: configurable width, parity and stop bits,
// 3-sample majority vote per bit, valid/ready output with error flags.
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int H    = OVERSAMPLE / 2;
  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0] SC_PRE  = SC_W'(H - 1);
  localparam logic [SC_W-1:0] SC_MID  = SC_W'(H);
  localparam logic [SC_W-1:0] SC_VOTE = SC_W'(H + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic ODD_BIT = 1'(PARITY_ODD);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;
  logic [SC_W-1:0]        sc;
  logic [3:0]             bit_cnt;
  logic                   arm;
  logic                   samp_a, samp_b;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_pend, frm_pend;
  logic                   at_vote, at_last, vote, start_det, complete;

  assign rxs       = sync[SYNC_STAGES-1];
  assign at_vote   = (sc == SC_VOTE);
  assign at_last   = (sc == SC_LAST);
  assign vote      = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
  assign start_det = (state == IDLE) && arm && !rxs;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], rx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    complete   = 1'b0;
    case (state)
      IDLE:   if (arm && !rxs) state_next = START;
      START: begin
        if (at_vote && vote) state_next = IDLE;
        else if (at_last)    state_next = DATA;
      end
      DATA:   if (at_last && bit_cnt == LAST_DATA)
                state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (at_last) state_next = STOP;
      // Leaving at mid-bit of the last stop bit leaves half a period to
      // catch the next start edge.
      STOP:   if (at_vote && bit_cnt == LAST_STOP) begin
                state_next = IDLE;
                complete   = 1'b1;
              end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc       <= '0;
      bit_cnt  <= '0;
      arm      <= 1'b0;
      samp_a   <= 1'b0;
      samp_b   <= 1'b0;
      shreg    <= '0;
      par_pend <= 1'b0;
      frm_pend <= 1'b0;
    end else begin
      // The detection cycle itself counts as sample 0 of the start bit.
      if (state == IDLE)            sc <= start_det ? SC_W'(1) : '0;
      else if (state_next == IDLE)  sc <= '0;
      else if (at_last)             sc <= '0;
      else                          sc <= sc + SC_W'(1);

      if (state != state_next)                             bit_cnt <= '0;
      else if (at_last && (state == DATA || state == STOP)) bit_cnt <= bit_cnt + 4'd1;

      // arm only rises while the line is high, so a break never re-triggers.
      if (state != IDLE)  arm <= 1'b0;
      else if (start_det) arm <= 1'b0;
      else if (rxs)       arm <= 1'b1;

      if (sc == SC_PRE) samp_a <= rxs;
      if (sc == SC_MID) samp_b <= rxs;

      if (state == DATA && at_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};

      if (start_det) par_pend <= 1'b0;
      else if (state == PARITY && at_vote && (vote != (^shreg ^ ODD_BIT)))
        par_pend <= 1'b1;

      if (start_det) frm_pend <= 1'b0;
      else if (state == STOP && at_vote && !vote) frm_pend <= 1'b1;
    end
  end

  // Handshake: a word transfers on any cycle with valid && ready; data_out and
  // flags hold while valid is high; a frame finishing against valid && !ready
  // is dropped with a one-cycle overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (valid && !ready) begin
          overrun <= 1'b1;
        end else begin
          data_out   <= shreg;
          parity_err <= (PARITY_EN != 0) && par_pend;
          frame_err  <= frm_pend | !vote;
          valid      <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
